io_pinmux_ctrl: RTL

//   Wishbone-configured pad function controller for user pads io[37:14], between soc_core and the pads.

---
 rtl/io_pinmux_ctrl_pkg.sv | 43 ++++
 rtl/io_pinmux_ctrl_if.sv | 29 ++
 rtl/io_pinmux_ctrl_pad_cell.sv | 48 ++++
 rtl/io_pinmux_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pinmux_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pinmux_pkg
//   Shared types and constants for the io_pinmux_ctrl pad function controller.
//   - fsel_e   : per-pad function select encoding (codes 2 and 3 both mean HIZ)
//   - state_e  : break-before-make sequencer states
//   - OFF_*    : Wishbone register byte offsets inside the 256-byte window
//   - sel_mask : expands Wishbone byte-lane selects into a 32-bit bit mask
// ---------------------------------------------------------------------------
package pinmux_pkg;

    localparam int NPADS_DEF = 24;
    localparam int GUARD_DEF = 4;

    typedef enum logic [1:0] {
        FSEL_PERIPH = 2'd0,
        FSEL_SWGPIO = 2'd1,
        FSEL_HIZ    = 2'd2
    } fsel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BREAK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [7:0] OFF_FSEL0  = 8'h00;
    localparam logic [7:0] OFF_FSEL1  = 8'h04;
    localparam logic [7:0] OFF_SWOUT  = 8'h08;
    localparam logic [7:0] OFF_SWOEB  = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;
    localparam logic [7:0] OFF_PADIN  = 8'h14;

    // Byte lane b enables bits [8b+7:8b]; merging is then (old & ~m) | (new & m).
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/io_pinmux_ctrl_if.sv
// ---------------------------------------------------------------------------
// io_pinmux_ctrl_if
//   Wishbone slave bundle for io_pinmux_ctrl. Signal names keep the
//   soc_core wbs_* naming so the bus maps one-to-one onto the SoC wiring.
//   master : drives stb/cyc/we/sel/adr/dat_i, receives ack/dat_o
//   slave  : receives stb/cyc/we/sel/adr/dat_i, drives ack/dat_o
// ---------------------------------------------------------------------------
interface io_pinmux_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/io_pinmux_ctrl_pad_cell.sv
// ---------------------------------------------------------------------------
// pinmux_pad_cell
//   Purely combinational output mux for one pad.
//   i_fsel       : committed function select (PERIPH / SWGPIO / HIZ)
//   i_force_hiz  : guard-interval override, wins over any selection
//   i_core_out/i_core_oeb : soc_core peripheral drive
//   i_sw_out/i_sw_oeb     : software GPIO drive
//   o_pad_out/o_pad_oeb   : to io_out / io_oeb (oeb=1 means not driven)
// ---------------------------------------------------------------------------
module pinmux_pad_cell
    import pinmux_pkg::*;
(
    input  logic [1:0] i_fsel,
    input  logic       i_force_hiz,
    input  logic       i_core_out,
    input  logic       i_core_oeb,
    input  logic       i_sw_out,
    input  logic       i_sw_oeb,
    output logic       o_pad_out,
    output logic       o_pad_oeb
);

    // Select the pad source; anything not explicitly a driver falls to high-Z.
    always_comb begin
        o_pad_out = 1'b0;
        o_pad_oeb = 1'b1;
        if (i_force_hiz) begin
            o_pad_out = 1'b0;
            o_pad_oeb = 1'b1;
        end else begin
            case (i_fsel)
                FSEL_PERIPH: begin
                    o_pad_out = i_core_out;
                    o_pad_oeb = i_core_oeb;
                end
                FSEL_SWGPIO: begin
                    o_pad_out = i_sw_out;
                    o_pad_oeb = i_sw_oeb;
                end
                default: begin
                    o_pad_out = 1'b0;
                    o_pad_oeb = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/io_pinmux_ctrl.sv
// ---------------------------------------------------------------------------
// io_pinmux_ctrl
//   Wishbone-configured pad function controller for user pads io[37:14]
//   (pad k = io[14+k]). Each pad is a core peripheral pass-through, a
//   software GPIO, or high-Z. Function changes are break-before-make: the
//   pads whose selection changes are tristated for GUARD_CYC cycles plus one
//   commit cycle before the new selection becomes active.
// Ports
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   wbs                    : Wishbone slave (io_pinmux_ctrl_if.slave)
//   core_out_i/core_oeb_i  : peripheral drive from soc_core
//   pad_in_i               : asynchronous pad inputs
//   pad_out_o/pad_oeb_o    : to io_out / io_oeb
//   busy_o                 : break/commit sequence in progress
// ---------------------------------------------------------------------------
module io_pinmux_ctrl
    import pinmux_pkg::*;
#(
    parameter int          NPADS     = NPADS_DEF,
    parameter int          GUARD_CYC = GUARD_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    io_pinmux_ctrl_if.slave  wbs,
    input  logic [NPADS-1:0] core_out_i,
    input  logic [NPADS-1:0] core_oeb_i,
    input  logic [NPADS-1:0] pad_in_i,
    output logic [NPADS-1:0] pad_out_o,
    output logic [NPADS-1:0] pad_oeb_o,
    output logic             busy_o
);

    localparam int FW    = 2 * NPADS;
    localparam int HW    = FW - 32;
    localparam int CNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(GUARD_CYC - 1);

    // Registered state
    logic             r_ack;
    logic [31:0]      r_dat;
    logic [FW-1:0]    r_pending;
    logic [FW-1:0]    r_active;
    logic [FW-1:0]    r_target;
    logic [NPADS-1:0] r_chg;
    logic [CNT_W-1:0] r_cnt;
    logic [NPADS-1:0] r_swout;
    logic [NPADS-1:0] r_swoeb;
    logic [NPADS-1:0] r_padin_meta;
    logic [NPADS-1:0] r_padin_sync;
    logic             r_busy;
    state_e           r_state;

    // Combinational helpers
    logic             w_hit;
    logic             w_req;
    logic             w_wr;
    logic [7:0]       w_off;
    logic [31:0]      w_mask;
    logic [31:0]      w_rdata;
    logic [FW-1:0]    w_pending_nxt;
    logic [NPADS-1:0] w_diff;
    state_e           w_state_nxt;
    logic             w_start;
    logic             w_cnt_dec;
    logic             w_commit;

    // The full low byte is decoded, so unaligned offsets land on "unmapped".
    assign w_hit  = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off  = wbs.wbs_adr_i[7:0];
    assign w_req  = wbs.wbs_stb_i & wbs.wbs_cyc_i & w_hit & ~r_ack;
    assign w_wr   = w_req & wbs.wbs_we_i;
    assign w_mask = sel_mask(wbs.wbs_sel_i);

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign busy_o        = r_busy;

    // Register read multiplexer; FSEL reads return the pending selection.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_off)
            OFF_FSEL0:  w_rdata = r_pending[31:0];
            OFF_FSEL1:  w_rdata = 32'(r_pending[FW-1:32]);
            OFF_SWOUT:  w_rdata = 32'(r_swout);
            OFF_SWOEB:  w_rdata = 32'(r_swoeb);
            OFF_STATUS: w_rdata = {31'h0000_0000, r_busy};
            OFF_PADIN:  w_rdata = 32'(r_padin_sync);
            default:    w_rdata = 32'h0000_0000;
        endcase
    end

    // Byte-lane merge of FSEL writes into the pending selection.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr && (w_off == OFF_FSEL0)) begin
            w_pending_nxt[31:0] = (r_pending[31:0] & ~w_mask) | (wbs.wbs_dat_i & w_mask);
        end else if (w_wr && (w_off == OFF_FSEL1)) begin
            w_pending_nxt[FW-1:32] = (r_pending[FW-1:32] & ~w_mask[HW-1:0])
                                   | (wbs.wbs_dat_i[HW-1:0] & w_mask[HW-1:0]);
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Pads whose pending selection differs from the committed one.
    always_comb begin
        w_diff = '0;
        for (int k = 0; k < NPADS; k++) begin
            w_diff[k] = (r_pending[2*k +: 2] != r_active[2*k +: 2]);
        end
    end

    // Wishbone ack/read data, pending FSEL and software GPIO registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'h0000_0000;
            r_pending <= '0;
            r_swout   <= '0;
            r_swoeb   <= '1;
        end else begin
            r_ack     <= w_req;
            r_pending <= w_pending_nxt;
            if (w_req && !wbs.wbs_we_i) begin
                r_dat <= w_rdata;
            end
            if (w_wr && (w_off == OFF_SWOUT)) begin
                r_swout <= (r_swout & ~w_mask[NPADS-1:0]) | (wbs.wbs_dat_i[NPADS-1:0] & w_mask[NPADS-1:0]);
            end
            if (w_wr && (w_off == OFF_SWOEB)) begin
                r_swoeb <= (r_swoeb & ~w_mask[NPADS-1:0]) | (wbs.wbs_dat_i[NPADS-1:0] & w_mask[NPADS-1:0]);
            end
        end
    end

    // Two-flop synchronizer for the asynchronous pad inputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_padin_meta <= '0;
            r_padin_sync <= '0;
        end else begin
            r_padin_meta <= pad_in_i;
            r_padin_sync <= r_padin_meta;
        end
    end

    // Sequencer state register; busy is registered alongside the state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != r_active) begin
                    w_state_nxt = ST_BREAK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer control strobes for the datapath.
    always_comb begin
        w_start   = 1'b0;
        w_cnt_dec = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            ST_IDLE:   w_start   = (r_pending != r_active);
            ST_BREAK:  w_cnt_dec = (r_cnt != '0);
            ST_COMMIT: w_commit  = 1'b1;
            default: begin
                w_start   = 1'b0;
                w_cnt_dec = 1'b0;
                w_commit  = 1'b0;
            end
        endcase
    end

    // Sequencer datapath: snapshot target, guard counter, commit.
    // r_chg stays set through COMMIT so a changing pad is only released
    // once the new selection is already in r_active.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_active <= '0;
            r_target <= '0;
            r_chg    <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_target <= r_pending;
            r_chg    <= w_diff;
            r_cnt    <= CNT_INIT;
        end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (w_commit) begin
            r_active <= r_target;
            r_chg    <= '0;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // One output mux per pad.
    for (genvar k = 0; k < NPADS; k++) begin : g_pad
        pinmux_pad_cell u_cell (
            .i_fsel      (r_active[2*k +: 2]),
            .i_force_hiz (r_chg[k]),
            .i_core_out  (core_out_i[k]),
            .i_core_oeb  (core_oeb_i[k]),
            .i_sw_out    (r_swout[k]),
            .i_sw_oeb    (r_swoeb[k]),
            .o_pad_out   (pad_out_o[k]),
            .o_pad_oeb   (pad_oeb_o[k])
        );
    end

endmodule
